imem_uart_loader: RTL and testbench

- Boot-time program loader. It receives a framed program image over a UART line and writes it word by word into instruction memory through that memory's write port.
- It writes the same memory that the fetch stage reads.
- It holds the core in reset (core_hold) until a complete, valid image has been written, then releases it.
- It sits at top level beside the core. core_hold is ORed into the core's reset.

---
 rtl/imem_uart_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader that writes a framed image into instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic [1:0] {L_IDLE, L_COUNT, L_DATA, L_CHECK} ld_t;
    rx_t rx_st_q, rx_st_d;
    ld_t ld_q, ld_d;
    logic rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic bv_q, bv_d, fe_q, fe_d;
    logic [7:0] n_q, n_d;
    logic [8:0] wcnt_q, wcnt_d, tgt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, wa_q, wa_d;
    logic [23:0] asm_q, asm_d;
    logic [1:0] bi_q, bi_d;
    logic [31:0] wd_q, wd_d;
    logic we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d, ok_q, ok_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
`endif
    always_comb begin
        rx_s1_d = rx;
        rx_s2_d = rx_s1_q;
        rx_s3_d = rx_s2_q;
        rx_st_d = rx_st_q;
        cnt_d = cnt_q + CW'(1);
        bit_d = bit_q;
        sh_d = sh_q;
        bv_d = 1'b0;
        fe_d = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                cnt_d = '0;
                rx_st_d = (rx_s3_q & ~rx_s2_q) ? RX_START : RX_IDLE;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d = '0;
                bit_d = '0;
                rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d = {rx_s2_q, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                rx_st_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (cnt_q == FULL) begin
                bv_d = rx_s2_q;
                fe_d = ~rx_s2_q;
                rx_st_d = RX_IDLE;
            end
        endcase
    end
    assign tgt = (n_q == 8'd0) ? 9'd256 : {1'b0, n_q};
    always_comb begin
        ld_d = ld_q;
        n_d = n_q;
        wcnt_d = wcnt_q;
        addr_d = addr_q;
        asm_d = asm_q;
        bi_d = bi_q;
        wa_d = wa_q;
        wd_d = wd_q;
        we_d = 1'b0;
        ok_d = 1'b0;
        err_d = err_q;
        done_d = done_q | ok_q;
        hold_d = hold_q & ~done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d = xor_q;
`endif
        case (ld_q)
            L_IDLE: if (bv_q && sh_q == 8'hA5) begin
                ld_d = L_COUNT;
                hold_d = 1'b1;
                done_d = 1'b0;
                err_d = 1'b0;
                wcnt_d = '0;
                addr_d = '0;
                bi_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_d = '0;
`endif
            end
            L_COUNT: if (bv_q) begin
                n_d = sh_q;
                ld_d = L_DATA;
            end
            L_DATA: if (bv_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_d = xor_q ^ sh_q;
`endif
                bi_d = bi_q + 2'd1;
                asm_d = {sh_q, asm_q[23:8]};
                if (bi_q == 2'd3) begin
                    we_d = 1'b1;
                    wd_d = {sh_q, asm_q};
                    wa_d = addr_q;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    wcnt_d = wcnt_q + 9'd1;
                    if (wcnt_q + 9'd1 == tgt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        ld_d = L_CHECK;
`else
                        ld_d = L_IDLE;
                        ok_d = 1'b1;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            L_CHECK: if (bv_q) begin
                ld_d = L_IDLE;
                ok_d = (sh_q == xor_q);
                err_d = (sh_q != xor_q);
            end
`endif
            default: ;
        endcase
        if (fe_q && ld_q != L_IDLE) begin
            err_d = 1'b1;
            ld_d = L_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
            rx_st_q <= RX_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q <= '0;
            bv_q <= 1'b0;
            fe_q <= 1'b0;
            ld_q <= L_IDLE;
            n_q <= '0;
            wcnt_q <= '0;
            addr_q <= '0;
            asm_q <= '0;
            bi_q <= '0;
            wa_q <= '0;
            wd_q <= '0;
            we_q <= 1'b0;
            ok_q <= 1'b0;
            hold_q <= 1'b1;
            done_q <= 1'b0;
            err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q <= '0;
`endif
        end else begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= {rx_s1_d, rx_s2_d, rx_s3_d};
            rx_st_q <= rx_st_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            bv_q <= bv_d;
            fe_q <= fe_d;
            ld_q <= ld_d;
            n_q <= n_d;
            wcnt_q <= wcnt_d;
            addr_q <= addr_d;
            asm_q <= asm_d;
            bi_q <= bi_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
            we_q <= we_d;
            ok_q <= ok_d;
            hold_q <= hold_d;
            done_q <= done_d;
            err_q <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q <= xor_d;
`endif
        end
    end
    assign imem_we = we_q;
    assign imem_addr = wa_q;
    assign imem_wdata = wd_q;
    assign core_hold = hold_q;
    assign done = done_q;
    assign error = err_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: directed frames into two loaders (8-bit and 2-bit address); writes checked against a scoreboard queue.
module tb_imem_uart_loader;
    localparam int CPB = 4;
    logic clk = 1'b0, reset = 1'b1, rx_drv = 1'b1, sel = 1'b0, bad_sum = 1'b0;
    logic rx0, rx1;
    logic we0, we1, hold0, hold1, done0, done1, err0, err1;
    logic [7:0] a0;
    logic [1:0] a1;
    logic [31:0] d0, d1;
    logic [39:0] exp0[$], exp1[$];
    logic [31:0] wq[$];
    int checks = 0, errors = 0;
    assign rx0 = sel ? 1'b1 : rx_drv;
    assign rx1 = sel ? rx_drv : 1'b1;
    always #5 clk = ~clk;
    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8)) dut0 (
        .clk(clk), .reset(reset), .rx(rx0), .imem_we(we0), .imem_addr(a0), .imem_wdata(d0),
        .core_hold(hold0), .done(done0), .error(err0));
    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(2)) dut1 (
        .clk(clk), .reset(reset), .rx(rx1), .imem_we(we1), .imem_addr(a1), .imem_wdata(d1),
        .core_hold(hold1), .done(done1), .error(err1));
    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    function automatic logic [2:0] st();
        return sel ? {hold1, done1, err1} : {hold0, done0, err0};
    endfunction
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            tick(CPB);
        end
        rx_drv = stop;
        tick(CPB);
        rx_drv = 1'b1;
        tick(CPB);
    endtask
    // bad: index of the data byte sent with a low stop bit, -1 for none
    task automatic send_frame(input logic [7:0] n, input int bad);
        logic [7:0] x, b, a;
        x = '0;
        a = '0;
        send_byte(8'hA5, 1'b1);
        send_byte(n, 1'b1);
        chk("load_start_hold_done", {37'd0, st()} >> 1, 40'b10);
        foreach (wq[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = wq[i][8*k +: 8];
                if (i * 4 + k == bad) begin
                    send_byte(b, 1'b0);
                    return;
                end
                if (k == 3) begin
                    if (sel) exp1.push_back({a & 8'h03, wq[i]});
                    else exp0.push_back({a, wq[i]});
                    a = a + 8'd1;
                end
                send_byte(b, 1'b1);
                x = x ^ b;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_sum ? ~x : x, 1'b1);
`else
        if (x === 8'hxx) chk("sum_model", {32'd0, x}, 40'd0);
`endif
    endtask
    task automatic wait_done(input string tag);
        for (int i = 0; i < 500 && st() !== 3'b010 && st() !== 3'b110; i++) tick(1);
        tick(3);
        chk(tag, {37'd0, st()}, 40'b010);
    endtask
    logic we0_p = 0, we1_p = 0, dn0_p = 0, dn1_p = 0, r0_p = 0, r1_p = 0;
    always @(negedge clk) begin
        if (we0) begin
            chk("wr0", {a0, d0}, exp0.size() > 0 ? exp0.pop_front() : 40'hx);
            chk("we0_pulse", {39'd0, we0_p}, 40'd0);
        end
        if (we1) begin
            chk("wr1", {6'd0, a1, d1}, exp1.size() > 0 ? exp1.pop_front() : 40'hx);
            chk("we1_pulse", {39'd0, we1_p}, 40'd0);
        end
        if (r0_p) chk("hold0_after_done", {39'd0, hold0}, 40'd0);
        if (done0 && !dn0_p) chk("hold0_at_done", {39'd0, hold0}, 40'd1);
        if (r1_p) chk("hold1_after_done", {39'd0, hold1}, 40'd0);
        if (done1 && !dn1_p) chk("hold1_at_done", {39'd0, hold1}, 40'd1);
        r0_p = done0 && !dn0_p;
        r1_p = done1 && !dn1_p;
        dn0_p = done0;
        dn1_p = done1;
        we0_p = we0;
        we1_p = we1;
    end
    initial begin
        tick(4);
        reset = 1'b0;
        tick(1);
        chk("reset_out", {hold0, done0, err0, we0, a0, d0[27:0]}, {4'b1000, 36'd0});
        tick(1000);
        chk("idle_out", {hold0, done0, err0, we0, a0, d0[27:0]}, {4'b1000, 36'd0});
        wq = '{32'h00000013, 32'h001000B3};
        send_frame(8'h02, -1);
        wait_done("frame2_done");
`ifdef IMEM_LOADER_CHECKSUM_EN
        bad_sum = 1'b1;
        send_frame(8'h02, -1);
        bad_sum = 1'b0;
        tick(20);
        chk("bad_sum", {37'd0, st()}, 40'b101);
        send_frame(8'h02, -1);
        wait_done("after_bad_sum_done");
`endif
        wq = '{32'hDDCCBBAA};
        send_frame(8'h01, 2);
        tick(20);
        chk("frame_err", {37'd0, st()}, 40'b101);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        tick(20);
        chk("ignored_bytes", {37'd0, st()}, 40'b101);
        wq = '{32'h12345678};
        send_frame(8'h01, -1);
        wait_done("after_err_done");
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back($urandom);
        send_frame(8'h00, -1);
        wait_done("n256_done");
        sel = 1'b1;
        wq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        send_frame(8'h05, -1);
        wait_done("wrap_done");
        sel = 1'b0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("midload_reset", {hold0, done0, err0, we0, a0, d0[27:0]}, {4'b1000, 36'd0});
        wq = '{32'hDEADBEEF};
        send_frame(8'h01, -1);
        wait_done("restart_done");
        tick(20);
        chk("exp0_drained", 40'(exp0.size()), 40'd0);
        chk("exp1_drained", 40'(exp1.size()), 40'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
